// File: rtl/cim_tile_model.sv
// Behavioural model of one compute-in-memory crossbar tile: input buffer, weight
// array, row-serial matrix-vector multiply and saturating result registers.
module cim_tile_model #(
  parameter int xbar_size     = 256,
  parameter int datatype_size = 2,
  parameter int acc_size      = 2*datatype_size+$clog2(xbar_size)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
  input  logic [datatype_size-1:0]     i_wr_data,
  input  logic                         i_w_we,
  input  logic [$clog2(xbar_size)-1:0] i_w_row,
  input  logic [$clog2(xbar_size)-1:0] i_w_col,
  input  logic [datatype_size-1:0]     i_w_data,
  input  logic                         i_exec,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
  output logic [datatype_size-1:0]     o_rd_data
);

  localparam int aw = $clog2(xbar_size);
  localparam logic [acc_size-1:0] sat_max = acc_size'((1 << datatype_size) - 1);

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t                   state_reg, state_next;
  logic [aw-1:0]            row_reg;
  logic [datatype_size-1:0] in_buf_reg [xbar_size];
  logic [datatype_size-1:0] w_reg      [xbar_size][xbar_size];
  logic [acc_size-1:0]      acc_reg    [xbar_size];
  logic [acc_size-1:0]      acc_next   [xbar_size];
  logic [datatype_size-1:0] sat_next   [xbar_size];
  logic [datatype_size-1:0] out_reg    [xbar_size];
  logic                     done_reg;
  logic [datatype_size-1:0] rd_data_reg;
  logic                     start, finish, last_row;

  assign last_row = (row_reg == aw'(xbar_size - 1));

  // One multiply-accumulate per column per cycle, all columns in parallel.
  genvar gi;
  generate
    for (gi = 0; gi < xbar_size; gi++) begin : g_col
      assign acc_next[gi] = acc_reg[gi]
                          + acc_size'(in_buf_reg[row_reg]) * acc_size'(w_reg[row_reg][gi]);
      assign sat_next[gi] = (acc_next[gi] > sat_max) ? {datatype_size{1'b1}}
                                                     : acc_next[gi][datatype_size-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_exec) begin
          start      = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (last_row) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // Writes land on the exec edge too, so they are visible to the first compute row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < xbar_size; r++) begin
        in_buf_reg[r] <= '0;
        for (int c = 0; c < xbar_size; c++) w_reg[r][c] <= '0;
      end
    end else if (state_reg == IDLE) begin
      if (i_wr_en) in_buf_reg[i_wr_addr] <= i_wr_data;
      if (i_w_we)  w_reg[i_w_row][i_w_col] <= i_w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_reg     <= '0;
      done_reg    <= 1'b0;
      rd_data_reg <= '0;
      for (int c = 0; c < xbar_size; c++) begin
        acc_reg[c] <= '0;
        out_reg[c] <= '0;
      end
    end else begin
      done_reg    <= finish;
      rd_data_reg <= out_reg[i_rd_addr];
      if (start) begin
        row_reg <= '0;
        for (int c = 0; c < xbar_size; c++) acc_reg[c] <= '0;
      end else if (state_reg == COMPUTE) begin
        row_reg <= row_reg + aw'(1);
        for (int c = 0; c < xbar_size; c++) acc_reg[c] <= acc_next[c];
        if (finish) begin
          for (int c = 0; c < xbar_size; c++) out_reg[c] <= sat_next[c];
        end
      end
    end
  end

  assign o_busy    = (state_reg == COMPUTE);
  assign o_done    = done_reg;
  assign o_rd_data = rd_data_reg;

endmodule

// File: tb/tb_cim_tile_model.sv
// Scoreboard bench for cim_tile_model (8x8 crossbar, 2-bit data): stimulus pushes
// expected reads and busy lengths, a negedge monitor pops and compares.
module tb_cim_tile_model;
  localparam int xs = 8;
  localparam int ds = 2;
  localparam int sat = (1 << ds) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [2:0]    i_wr_addr = '0;
  logic [ds-1:0] i_wr_data = '0;
  logic          i_w_we = 1'b0;
  logic [2:0]    i_w_row = '0;
  logic [2:0]    i_w_col = '0;
  logic [ds-1:0] i_w_data = '0;
  logic          i_exec = 1'b0;
  logic          o_busy, o_done;
  logic [2:0]    i_rd_addr = '0;
  logic [ds-1:0] o_rd_data;

  cim_tile_model #(.xbar_size(xs), .datatype_size(ds)) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
    .i_exec(i_exec), .o_busy(o_busy), .o_done(o_done),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: what the tile should hold, and the results it should expose.
  int in_m [xs];
  int w_m  [xs][xs];
  int out_m [xs];
  int pend_m [xs];

  int rd_q [$];
  int rd_col_q [$];
  int done_q [$];
  logic rd_req = 1'b0;
  logic rd_valid_d = 1'b0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_valid_d <= rd_req;

  // Monitor: compares read data one cycle after the request and busy length at done.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (rd_valid_d) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_valid_d), 0);
        else begin
          int col;
          col = rd_col_q.pop_front();
          check($sformatf("rd_col%0d", col), 32'(o_rd_data), 32'(rd_q.pop_front()));
        end
      end
      if (o_busy) busy_cnt++;
      if (o_done) begin
        if (done_q.size() == 0) check("done_unexpected", 32'(o_done), 0);
        else check("busy_cycles", 32'(busy_cnt), 32'(done_q.pop_front()));
        busy_cnt = 0;
      end
    end
  end

  function automatic void model_mvm();
    for (int c = 0; c < xs; c++) begin
      int sum;
      sum = 0;
      for (int r = 0; r < xs; r++) sum += in_m[r] * w_m[r][c];
      pend_m[c] = (sum > sat) ? sat : sum;
    end
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < xs; r++) begin
      in_m[r] = 0;
      out_m[r] = 0;
      for (int c = 0; c < xs; c++) w_m[r][c] = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_in(input int r, input int d);
    i_wr_en = 1'b1; i_wr_addr = 3'(r); i_wr_data = 2'(d);
    tick();
    i_wr_en = 1'b0;
    in_m[r] = d;
  endtask

  task automatic write_w(input int r, input int c, input int d);
    i_w_we = 1'b1; i_w_row = 3'(r); i_w_col = 3'(c); i_w_data = 2'(d);
    tick();
    i_w_we = 1'b0;
    w_m[r][c] = d;
  endtask

  task automatic start_exec();
    model_mvm();
    done_q.push_back(xs);
    i_exec = 1'b1;
    tick();
    i_exec = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'(o_done), 1);
    for (int c = 0; c < xs; c++) out_m[c] = pend_m[c];
    tick();
  endtask

  task automatic read_col(input int c);
    i_rd_addr = 3'(c);
    rd_req = 1'b1;
    rd_q.push_back(out_m[c]);
    rd_col_q.push_back(c);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int c = 0; c < xs; c++) read_col(c);
  endtask

  task automatic run();
    start_exec();
    wait_done();
    read_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    model_clear();
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_rd_data", 32'(o_rd_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Identity weights
    for (int r = 0; r < xs; r++) write_w(r, r, 1);
    for (int r = 0; r < xs; r++) write_in(r, r % 4);
    run();

    // Reads during compute return the previous result
    for (int r = 0; r < xs; r++) write_in(r, 0);
    start_exec();
    read_col(2);
    wait_done();
    read_col(2);

    // Writes and exec during compute are ignored
    for (int r = 0; r < xs; r++) write_in(r, r % 4);
    start_exec();
    i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 2'd3;
    i_w_we = 1'b1; i_w_row = 3'd0; i_w_col = 3'd0; i_w_data = 2'd3;
    i_exec = 1'b1;
    tick();
    i_wr_en = 1'b0; i_w_we = 1'b0; i_exec = 1'b0;
    wait_done();
    read_all();
    run();

    // Saturation: 8 * 3 * 3 = 72 clips to 3
    for (int r = 0; r < xs; r++)
      for (int c = 0; c < xs; c++) write_w(r, c, 3);
    for (int r = 0; r < xs; r++) write_in(r, 3);
    run();

    // Reset in the fourth compute cycle aborts the run
    start_exec();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(o_busy), 0);
    check("abort_done", 32'(o_done), 0);
    void'(done_q.pop_back());
    model_clear();
    tick();
    tick();
    rst = 1'b1;
    repeat (12) tick();
    read_all();

    // Input and weight writes on the same edge as exec participate
    write_w(5, 5, 1);
    write_in(3, 1);
    i_wr_en = 1'b1; i_wr_addr = 3'd5; i_wr_data = 2'd2;
    i_w_we = 1'b1; i_w_row = 3'd3; i_w_col = 3'd3; i_w_data = 2'd1;
    in_m[5] = 2;
    w_m[3][3] = 1;
    start_exec();
    i_wr_en = 1'b0; i_w_we = 1'b0;
    wait_done();
    read_all();

    // Exec held high restarts right after done
    model_mvm();
    done_q.push_back(xs);
    done_q.push_back(xs);
    i_exec = 1'b1;
    tick();
    wait_done();
    i_exec = 1'b0;
    check("held_exec_restart", 32'(o_busy), 1);
    wait_done();
    read_all();

    // Randomised sparse matrices
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < xs; r++)
        for (int c = 0; c < xs; c++)
          write_w(r, c, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0);
      for (int r = 0; r < xs; r++) write_in(r, int'($urandom_range(0, 3)));
      run();
    end

    repeat (4) tick();
    check("rd_queue_drained", 32'(rd_q.size()), 0);
    check("done_queue_drained", 32'(done_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cim_tile_model.md
CIM_TILE_MODEL -- requirements
Module: cim_tile_model

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter xbar_size, default 256, giving crossbar rows and columns.
REQ-002 The block SHALL have parameter datatype_size, default 2, giving the unsigned element width.
REQ-003 The block SHALL have parameter acc_size, default 2*datatype_size+$clog2(xbar_size), giving the accumulator width.

Ports (name, direction, width, meaning; aw = $clog2(xbar_size)):
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port i_wr_en, input, 1, input-vector write strobe.
REQ-007 The block SHALL have port i_wr_addr, input, aw, input-vector row address.
REQ-008 The block SHALL have port i_wr_data, input, datatype_size, input-vector element.
REQ-009 The block SHALL have port i_w_we, input, 1, weight write strobe.
REQ-010 The block SHALL have port i_w_row, input, aw, weight row.
REQ-011 The block SHALL have port i_w_col, input, aw, weight column.
REQ-012 The block SHALL have port i_w_data, input, datatype_size, weight value.
REQ-013 The block SHALL have port i_exec, input, 1, MVM start pulse.
REQ-014 The block SHALL have port o_busy, output, 1, MVM in progress.
REQ-015 The block SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-016 The block SHALL have port i_rd_addr, input, aw, result column address.
REQ-017 The block SHALL have port o_rd_data, output, datatype_size, result element.

Function
REQ-018 The block SHALL be the tile-side responder to a layer's CIM write, busy and read signals, modelling one crossbar tile.
REQ-019 The block SHALL hold an input buffer of xbar_size x datatype_size bits, written at i_wr_addr on a clk edge with i_wr_en=1 while state is IDLE.
REQ-020 The block SHALL hold a weight array of xbar_size x xbar_size x datatype_size bits, written on i_w_we=1 in IDLE only.
REQ-021 The block SHALL ignore i_wr_en, i_w_we and i_exec while in COMPUTE, with no state change.
REQ-022 The state machine SHALL have two states: IDLE, and COMPUTE.
REQ-023 An edge in IDLE with i_exec=1 SHALL clear all xbar_size accumulators, set the row counter to 0, and enter COMPUTE.
REQ-024 In COMPUTE, each cycle SHALL add in_buf[row]*w[row][c] (unsigned) to acc[c] for all columns c, then increment row.
REQ-025 COMPUTE SHALL last exactly xbar_size cycles, with o_busy=1 on each of them.
REQ-026 After the last row, the block SHALL load every output register with min(acc[c], 2^datatype_size-1), assert o_done for one cycle, and return to IDLE with o_busy=0.
REQ-027 Accumulators SHALL never overflow, because acc_size is sufficient.
REQ-028 Saturation SHALL be the only narrowing.
REQ-029 The output registers SHALL update only at completion, so reads during COMPUTE return the previous result.
REQ-030 o_rd_data SHALL be registered: the value of out[i_rd_addr] sampled at edge N appears after edge N, giving 1-cycle latency in any state.
REQ-031 i_wr_en and i_exec asserted on the same IDLE edge SHALL store the write first, so the new value participates in the MVM.
REQ-032 i_w_we and i_exec asserted on the same IDLE edge SHALL store the weight first, so the new weight participates in the MVM.
REQ-033 An i_exec held high SHALL start a new MVM on the first IDLE edge after o_done.

Reset
REQ-034 rst=0 SHALL asynchronously force state IDLE, row counter 0, o_busy=0, o_done=0, o_rd_data=0, all output registers 0, and all accumulators 0.
REQ-035 The input buffer and weight array SHALL also reset to 0.
REQ-036 Reset asserted mid-COMPUTE SHALL abort the operation with no o_done and no output update.
REQ-037 Operation SHALL resume on the first edge after rst returns high.

Verification (run with xbar_size=8, datatype_size=2)
REQ-038 Identity scenario: write w[r][r]=1, in=[0,1,2,3,0,1,2,3], pulse i_exec -> o_busy high 8 cycles, o_done 1 cycle, reads of columns 0..7 return 0,1,2,3,0,1,2,3.
REQ-039 Saturation scenario: set all weights=3 and all inputs=3, then run -> every column reads 3 (acc=72 clipped).
REQ-040 Busy isolation scenario: during COMPUTE, apply i_wr_en to row 0 with data 3 and i_w_we -> result unchanged versus the run without them; a later run uses the old buffer contents.
REQ-041 Read-during-compute scenario: after the identity run, start a run with all inputs=0 and read column 2 mid-COMPUTE -> 2; after o_done, read -> 0.
REQ-042 Reset scenario: drop rst at COMPUTE cycle 4 -> o_busy=0 immediately, no o_done, all reads 0.
REQ-043 Simultaneous-event scenario: in IDLE, write in[5]=2 on the same edge as i_exec, with w[5][5]=1 -> column 5 reads 2.
